// File: rtl/sr_word_loader_if.sv
// sr_word_loader_if: valid/ready word channel into the shift-register loader.
// master drives in_data/in_dir/in_valid; slave returns in_ready.
interface sr_word_loader_if #(
  parameter int MSB = 16
);
  logic [MSB-1:0] in_data;
  logic           in_dir;
  logic           in_valid;
  logic           in_ready;

  modport master (
    output in_data,
    output in_dir,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_dir,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sr_word_loader.sv
// sr_word_loader: serialises accepted words onto a serial-in shift register.
// Ports: clk, rstn, in_bus (word channel), abort, sr_d/sr_en/sr_dir, busy, frame_done, frame_cnt.
module sr_word_loader #(
  parameter int MSB  = 16,
  parameter int GAP  = 2,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rstn,
  sr_word_loader_if.slave in_bus,
  input  logic            abort,
  output logic            sr_d,
  output logic            sr_en,
  output logic            sr_dir,
  output logic            busy,
  output logic            frame_done,
  output logic [CNTW-1:0] frame_cnt
);

  localparam int BW = $clog2(MSB);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] LAST = BW'(MSB - 1);
  localparam logic [GW-1:0] GAP_LD =
    (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_cnt_n;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   gap_cnt_n;
  logic [MSB-1:0]  shadow;
  logic [MSB-1:0]  shadow_n;
  logic [MSB-1:0]  nxt;
  logic            sr_d_n;
  logic            sr_en_n;
  logic            sr_dir_n;
  logic            done_n;
  logic [CNTW-1:0] cnt_n;
  logic            ready;
  logic            accept;

  assign ready           = (state == S_IDLE) && !abort;
  assign in_bus.in_ready = ready;
  assign accept          = ready && in_bus.in_valid;
  assign busy            = (state != S_IDLE);

  // The shadow is shifted so the outgoing bit is always at a fixed end:
  // MSB end for MSB-first frames, bit 0 for LSB-first frames.
  assign nxt = sr_dir ? (shadow >> 1) : (shadow << 1);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    shadow_n  = shadow;
    sr_d_n    = 1'b0;
    sr_en_n   = 1'b0;
    sr_dir_n  = sr_dir;
    done_n    = 1'b0;
    cnt_n     = frame_cnt;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_SHIFT;
          shadow_n  = in_bus.in_data;
          sr_dir_n  = in_bus.in_dir;
          bit_cnt_n = '0;
          sr_en_n   = 1'b1;
          sr_d_n    = in_bus.in_dir ?
                      in_bus.in_data[0] :
                      in_bus.in_data[MSB-1];
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (bit_cnt == LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          cnt_n   = frame_cnt + CNTW'(1);
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
          shadow_n  = nxt;
          sr_en_n   = 1'b1;
          sr_d_n    = sr_dir ? nxt[0] : nxt[MSB-1];
        end
      end
      S_DONE: begin
        if (GAP == 0) begin
          state_n = S_IDLE;
        end else begin
          state_n   = S_GAP;
          gap_cnt_n = GAP_LD;
        end
      end
      S_GAP: begin
        // Counts down so the reset value of zero leaves GAP after one edge.
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_GAP;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shadow     <= '0;
      sr_d       <= 1'b0;
      sr_en      <= 1'b0;
      sr_dir     <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      shadow     <= shadow_n;
      sr_d       <= sr_d_n;
      sr_en      <= sr_en_n;
      sr_dir     <= sr_dir_n;
      frame_done <= done_n;
      frame_cnt  <= cnt_n;
    end
  end

endmodule
